// File: rtl/seg_anim_controller.sv
// seg_anim_controller
//   Drives six segments (A..F) of a seven-segment digit with one of four
//   animations. Three level buttons are edge-detected: Mode advances the
//   animation (with a one-period blank), Speed doubles the step period
//   (wrapping after four presses) and Pause freezes/resumes the animation.
//
// Ports
//   clock       : single clock, rising edge
//   reset       : synchronous, active-high
//   io_btnMode  : mode-advance request (level, synchronous)
//   io_btnSpeed : speed-advance request (level, synchronous)
//   io_btnPause : pause-toggle request (level, synchronous)
//   io_segAtoF  : active-high segments, bit0 = A .. bit5 = F
//   io_mode     : current animation mode
//   io_speed    : current speed level
//   io_paused   : high while the animation is held
module seg_anim_controller #(
    parameter int unsigned DIV_BASE = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_btnMode,
    input  logic       io_btnSpeed,
    input  logic       io_btnPause,
    output logic [5:0] io_segAtoF,
    output logic [1:0] io_mode,
    output logic [1:0] io_speed,
    output logic       io_paused
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [1:0]  speed_q, speed_d;
    logic [3:0]  step_q, step_d;
    logic [19:0] presc_q, presc_d;
    logic        prev_mode_q, prev_speed_q, prev_pause_q;

    logic        ev_mode, ev_speed, ev_pause;
    logic        tick;
    logic [19:0] period;
    logic [3:0]  last_step;
    logic [3:0]  prev_step;

    assign ev_mode  = io_btnMode  & ~prev_mode_q;
    assign ev_speed = io_btnSpeed & ~prev_speed_q;
    assign ev_pause = io_btnPause & ~prev_pause_q;

    // DIV_BASE <= 65535 shifted by at most 3 still fits in 20 bits.
    assign period = 20'(DIV_BASE) << speed_q;
    // The prescaler is frozen in HOLD, so no tick can fire there.
    assign tick   = (state_q != ST_HOLD) && (presc_q == period - 20'd1);

    always_comb begin
        case (mode_q)
            2'd2:    last_step = 4'd11;
            2'd3:    last_step = 4'd1;
            default: last_step = 4'd5;
        endcase
    end

    // Priority: mode event > pause event; speed event applies regardless.
    // Pause legality is judged on the current state, so a pause arriving on
    // the tick that ends BLANK is still ignored.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        speed_d = speed_q;
        step_d  = step_q;
        presc_d = presc_q;

        if (state_q != ST_HOLD) begin
            if (tick) begin
                presc_d = '0;
                if (state_q == ST_RUN) begin
                    step_d = (step_q == last_step) ? '0 : step_q + 4'd1;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                presc_d = presc_q + 20'd1;
            end
        end

        if (ev_mode) begin
            mode_d  = mode_q + 2'd1;
            step_d  = '0;
            presc_d = '0;
            state_d = ST_BLANK;
        end else if (ev_pause) begin
            if (state_q == ST_RUN) begin
                state_d = ST_HOLD;
            end else if (state_q == ST_HOLD) begin
                state_d = ST_RUN;
            end
        end

        if (ev_speed) begin
            speed_d = speed_q + 2'd1;
            presc_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            mode_q       <= '0;
            speed_q      <= '0;
            step_q       <= '0;
            presc_q      <= '0;
            prev_mode_q  <= 1'b0;
            prev_speed_q <= 1'b0;
            prev_pause_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            speed_q      <= speed_d;
            step_q       <= step_d;
            presc_q      <= presc_d;
            prev_mode_q  <= io_btnMode;
            prev_speed_q <= io_btnSpeed;
            prev_pause_q <= io_btnPause;
        end
    end

    // (step + 5) mod 6 for the trailing segment of the two-segment chase.
    assign prev_step = (step_q == 4'd0) ? 4'd5 : step_q - 4'd1;

    always_comb begin
        io_segAtoF = '0;
        if (state_q != ST_BLANK) begin
            case (mode_q)
                2'd0: io_segAtoF = 6'd1 << step_q;
                2'd1: io_segAtoF = (6'd1 << step_q) | (6'd1 << prev_step);
                2'd2: begin
                    if (step_q < 4'd6) begin
                        io_segAtoF = 6'((7'd2 << step_q) - 7'd1);
                    end else begin
                        io_segAtoF = 6'h3F << (step_q - 4'd5);
                    end
                end
                default: io_segAtoF = step_q[0] ? 6'h00 : 6'h3F;
            endcase
        end
    end

    assign io_mode   = mode_q;
    assign io_speed  = speed_q;
    assign io_paused = (state_q == ST_HOLD);

endmodule

// File: tb/tb_seg_anim_controller.sv
// Self-checking bench for seg_anim_controller (DIV_BASE = 2): directed
// scenarios with literal expectations plus a randomized run, all compared
// every cycle against a behavioural model of the animation rules.
module tb_seg_anim_controller;

    localparam int DIV = 2;
    localparam int RUN = 0, HOLD = 1, BLANK = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       io_btnMode = 1'b0, io_btnSpeed = 1'b0, io_btnPause = 1'b0;
    logic [5:0] io_segAtoF;
    logic [1:0] io_mode, io_speed;
    logic       io_paused;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    int m_mode = 0, m_speed = 0, m_step = 0, m_cnt = 0, m_state = RUN;
    int pm = 0, ps = 0, pp = 0;
    int mlen [4] = '{6, 6, 12, 2};
    bit started = 1'b0;

    seg_anim_controller #(.DIV_BASE(DIV)) dut (
        .clock       (clk),
        .reset       (rst),
        .io_btnMode  (io_btnMode),
        .io_btnSpeed (io_btnSpeed),
        .io_btnPause (io_btnPause),
        .io_segAtoF  (io_segAtoF),
        .io_mode     (io_mode),
        .io_speed    (io_speed),
        .io_paused   (io_paused)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int model_seg(input int md, input int sp, input int st);
        int v;
        if (st == BLANK) return 0;
        case (md)
            0:       v = 1 << sp;
            1:       v = (1 << sp) | (1 << ((sp + 5) % 6));
            2:       v = (sp < 6) ? ((2 << sp) - 1) : (63 & (63 << (sp - 5)));
            default: v = (sp == 0) ? 63 : 0;
        endcase
        return v & 63;
    endfunction

    task automatic model_step();
        int em, es, ep, s0, period;
        if (rst) begin
            m_mode = 0; m_speed = 0; m_step = 0; m_cnt = 0; m_state = RUN;
            pm = 0; ps = 0; pp = 0;
        end else begin
            em = (io_btnMode  && pm == 0) ? 1 : 0;
            es = (io_btnSpeed && ps == 0) ? 1 : 0;
            ep = (io_btnPause && pp == 0) ? 1 : 0;
            pm = int'(io_btnMode); ps = int'(io_btnSpeed); pp = int'(io_btnPause);
            s0 = m_state;
            period = DIV * (1 << m_speed);
            if (s0 != HOLD) begin
                if (m_cnt == period - 1) begin
                    m_cnt = 0;
                    if (s0 == RUN) m_step = (m_step + 1) % mlen[m_mode];
                    else m_state = RUN;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (em != 0) begin
                m_mode = (m_mode + 1) % 4; m_step = 0; m_cnt = 0; m_state = BLANK;
            end else if (ep != 0 && s0 != BLANK) begin
                m_state = (s0 == RUN) ? HOLD : RUN;
            end
            if (es != 0) begin
                m_speed = (m_speed + 1) % 4; m_cnt = 0;
            end
        end
        started = 1'b1;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Every-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (started) begin
            check("seg",    int'(io_segAtoF), model_seg(m_mode, m_step, m_state));
            check("mode",   int'(io_mode),    m_mode);
            check("speed",  int'(io_speed),   m_speed);
            check("paused", int'(io_paused),  (m_state == HOLD) ? 1 : 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_mode();
        io_btnMode = 1'b1; cyc(1); io_btnMode = 1'b0; cyc(1);
    endtask

    task automatic pulse_speed();
        io_btnSpeed = 1'b1; cyc(1); io_btnSpeed = 1'b0; cyc(1);
    endtask

    // Press Mode, expect two blank cycles, then each listed pattern for two
    // cycles (speed 0). Element j sits at bits [71-6j -: 6].
    task automatic mode_follow(input string nm, input int exp_mode,
                               input logic [71:0] seq, input int len);
        io_btnMode = 1'b1; cyc(1); io_btnMode = 1'b0;
        check({nm, "_mode"},   int'(io_mode), exp_mode);
        check({nm, "_blank1"}, int'(io_segAtoF), 0);
        cyc(1);
        check({nm, "_blank2"}, int'(io_segAtoF), 0);
        cyc(1);
        for (int j = 0; j < len; j++) begin
            for (int r = 0; r < 2; r++) begin
                check({nm, "_pat"}, int'(io_segAtoF), int'(seq[71 - 6 * j -: 6]));
                cyc(1);
            end
        end
    endtask

    initial begin
        logic [5:0] free_seq [6];
        int found;
        free_seq = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};

        // Reset state
        cyc(3);
        check("rst_seg",    int'(io_segAtoF), 1);
        check("rst_mode",   int'(io_mode),    0);
        check("rst_speed",  int'(io_speed),   0);
        check("rst_paused", int'(io_paused),  0);
        rst = 1'b0;

        // Free run: each one-hot pattern held two cycles
        for (int i = 0; i < 14; i++) begin
            check("free_run", int'(io_segAtoF), int'(free_seq[(i / 2) % 6]));
            cyc(1);
        end

        // Speed: one pulse -> 1, four pulses total -> wraps to 0
        pulse_speed();
        check("speed_one", int'(io_speed), 1);
        cyc(12);
        repeat (3) pulse_speed();
        check("speed_wrap", int'(io_speed), 0);

        // Pause during step 3 of mode 0
        found = 0;
        for (int k = 0; k < 100 && found == 0; k++) begin
            if (m_mode == 0 && m_step == 3 && m_state == RUN) found = 1;
            else cyc(1);
        end
        check("wait_step3", found, 1);
        io_btnPause = 1'b1; cyc(1); io_btnPause = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("hold_paused", int'(io_paused), 1);
            check("hold_seg", int'(io_segAtoF), 6'h08);
            cyc(1);
        end
        io_btnPause = 1'b1; cyc(1); io_btnPause = 1'b0;
        check("resume_paused", int'(io_paused), 0);
        cyc(1);
        check("resume_seg", int'(io_segAtoF), 6'h10);
        cyc(2);

        // Mode sequences
        mode_follow("mode1", 1, {6'h21, 6'h03, 6'h06, 6'h0C, 6'h18, 6'h30, 36'h0}, 6);
        mode_follow("mode2", 2, {6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3F,
                                 6'h3E, 6'h3C, 6'h38, 6'h30, 6'h20, 6'h00}, 12);
        mode_follow("mode3", 3, {6'h3F, 6'h00, 60'h0}, 2);

        // Simultaneous mode + pause: mode wins, pause dropped
        io_btnMode = 1'b1; io_btnPause = 1'b1; cyc(1);
        io_btnMode = 1'b0; io_btnPause = 1'b0;
        check("simul_mode",   int'(io_mode),   0);
        check("simul_paused", int'(io_paused), 0);
        cyc(4);

        // Held button gives exactly one event
        io_btnSpeed = 1'b1; cyc(10); io_btnSpeed = 1'b0; cyc(1);
        check("held_speed", int'(io_speed), 1);
        repeat (3) pulse_speed();
        check("held_wrap", int'(io_speed), 0);

        // Reset while held in mode 2
        pulse_mode(); pulse_mode(); cyc(3);
        io_btnPause = 1'b1; cyc(1); io_btnPause = 1'b0;
        check("pre_rst_paused", int'(io_paused), 1);
        check("pre_rst_mode",   int'(io_mode),   2);
        rst = 1'b1; cyc(1);
        check("mid_rst_mode",   int'(io_mode),    0);
        check("mid_rst_paused", int'(io_paused),  0);
        check("mid_rst_seg",    int'(io_segAtoF), 1);
        rst = 1'b0; cyc(2);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            io_btnMode  = ($urandom_range(0, 15) == 0);
            io_btnSpeed = ($urandom_range(0, 19) == 0);
            io_btnPause = ($urandom_range(0, 9) == 0);
            rst         = ($urandom_range(0, 399) == 0);
            cyc(1);
        end
        rst = 1'b0; io_btnMode = 1'b0; io_btnSpeed = 1'b0; io_btnPause = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
